pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised pipeline-stage register for the processor pipeline; it is the successor to the fixed IF/ID latch. It carries instruction, PC+4 and exception-vector fields between any two stages through a two-entry skid buffer with valid/ready handshaking, so back-pressure never has a combinational path upstream. Flush discards all held entries and presents a zero (NOP) payload. A saturating counter records discarded valid instructions for performance monitoring.

## Interface
- INS_W, 32, instruction field width
- PC_W, 32, PC+4 field width
- VEC_W, 5, exception/interrupt vector field width
- CNT_W, 16, width of flushed-instruction counter
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream presents a valid entry
- in_ready  out  1  stage can accept an entry; registered
- in_ins  in  INS_W  instruction
- in_pc_4  in  PC_W  PC+4
- in_vector  in  VEC_W  vector
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head entry
- out_ins  out  INS_W  head instruction
- out_pc_4  out  PC_W  head PC+4
- out_vector  out  VEC_W  head vector
- flush  in  1  discard all held entries and any same-cycle input
- flush_cnt  out  CNT_W  saturating count of valid entries discarded by flush

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_*), skid register. States: EMPTY, ONE (main full), FULL (main+skid full).
- in_ready = (state != FULL); out_valid = (state != EMPTY). Both are decoded from the state register only.
- EMPTY: in_fire -> ONE, main <= in.
- ONE: in_fire & out_fire -> ONE, main <= in. out_fire only -> EMPTY. in_fire only -> FULL, skid <= in. Neither -> hold.
- FULL: out_fire -> ONE, main <= skid, skid <= 0. Otherwise hold. No input is accepted.
- Priority: reset > flush > handshake. Flush -> EMPTY with main and skid zeroed. In-flight in_fire and out_fire that cycle are ignored (the consumer must also ignore out_fire on a flush cycle).
- Zero-payload rule: whenever an entry empties (pop without refill, flush, reset), its payload is zeroed. This makes out_* all-zero (NOP) whenever out_valid=0.
- flush_cnt: on flush, add the number of held entries (0/1/2). Entries arriving on in_fire that cycle are not counted. Saturate at 2^CNT_W-1, with no wrap. Cleared only by reset.

## Timing
- Reset (async assert, sync-clean deassert by system): state=EMPTY, out_valid=0, in_ready=1, out_ins/out_pc_4/out_vector=0, skid=0, flush_cnt=0.
- Latency: in_fire at edge N -> out_valid=1 with that payload after edge N (visible cycle N+1).
- Throughput: 1 entry/cycle when out_ready held high.
- out_ready drop: at most one further entry is absorbed (into skid). in_ready falls the cycle after skid fills.
- in_ready rises the cycle after the FULL -> ONE pop.
- Order is strictly FIFO: the skid entry never overtakes main.
- Reset mid-operation: all entries are lost immediately and are not counted in flush_cnt.

## Structure
- Shared package pipe_pkg: state encodings (ST_EMPTY, ST_ONE, ST_FULL) and NOP payload constant (all zeros).
- Sub-module pipe_entry: one payload register (ins, pc_4, vector) with load, clear and async active-low reset. It is instantiated twice, as main and skid.
- Top module holds the state machine, handshake decode and flush counter.

## Test plan
- Reset then stream: in_valid=1 with ins=0x11,0x22,0x33 and out_ready=1 -> out_ins 0x11,0x22,0x33 on consecutive cycles, one cycle after each accept; in_ready stays 1.
- Back-pressure: out_ready=0 while streaming 0xA1,0xA2,0xA3 -> state FULL holding A1/A2, in_ready=0 from the next cycle, A3 not accepted. Raise out_ready -> A1, A2, A3 emitted in order.
- Flush in FULL with in_valid=1: flush=1 -> next cycle out_valid=0, out_* all zero, in_ready=1, flush_cnt += 2. The input of the flush cycle is never emitted.
- Pop to empty: single entry ins=0xDEADBEEF, vector=5'h1F, popped with no refill -> out_valid=0 and out_ins=0, out_vector=0.
- Counter saturation (CNT_W=2): repeated flushes in FULL -> flush_cnt goes 0, 2, 3, 3.
- Async reset asserted mid-stream between clock edges -> outputs zero immediately, flush_cnt=0, in_ready=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: state encodings and NOP fill value shared by the pipeline-stage register.
package pipe_pkg;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;
    localparam logic NOP_BIT = 1'b0;
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one payload register (ins, pc_4, vector); clear wins over load and refills with NOP.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int INS_W = 32,
    parameter int PC_W  = 32,
    parameter int VEC_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [INS_W-1:0] ins,
    input  logic [PC_W-1:0]  pc_4,
    input  logic [VEC_W-1:0] vector,
    output logic [INS_W-1:0] held_ins,
    output logic [PC_W-1:0]  held_pc_4,
    output logic [VEC_W-1:0] held_vector
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || clear) begin
            held_ins    <= {INS_W{NOP_BIT}};
            held_pc_4   <= {PC_W{NOP_BIT}};
            held_vector <= {VEC_W{NOP_BIT}};
        end else if (load) begin
            held_ins    <= ins;
            held_pc_4   <= pc_4;
            held_vector <= vector;
        end
    end
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid pipeline register with registered ready, flush-to-NOP and
// a saturating count of valid entries discarded by flush.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int INS_W = 32,
    parameter int PC_W  = 32,
    parameter int VEC_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INS_W-1:0] in_ins,
    input  logic [PC_W-1:0]  in_pc_4,
    input  logic [VEC_W-1:0] in_vector,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INS_W-1:0] out_ins,
    output logic [PC_W-1:0]  out_pc_4,
    output logic [VEC_W-1:0] out_vector,
    input  logic             flush,
    output logic [CNT_W-1:0] flush_cnt
);
    state_t           state, state_nxt;
    logic             in_fire, out_fire;
    logic             main_load, main_clear, main_from_skid, skid_load, skid_clear;
    logic [INS_W-1:0] skid_ins;
    logic [PC_W-1:0]  skid_pc_4;
    logic [VEC_W-1:0] skid_vector;
    logic [1:0]       held;
    logic [CNT_W:0]   cnt_sum;

    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    // Flush overrides any handshake in the same cycle.
    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_nxt  = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    state_nxt = in_fire ? ST_ONE : ST_EMPTY;
                    main_load = in_fire;
                end
                ST_ONE: begin
                    state_nxt  = (in_fire && !out_fire) ? ST_FULL :
                                 (!in_fire && out_fire) ? ST_EMPTY : ST_ONE;
                    main_load  = in_fire && out_fire;
                    main_clear = !in_fire && out_fire;
                    skid_load  = in_fire && !out_fire;
                end
                ST_FULL: begin
                    state_nxt      = out_fire ? ST_ONE : ST_FULL;
                    main_load      = out_fire;
                    main_from_skid = out_fire;
                    skid_clear     = out_fire;
                end
                default: begin
                    state_nxt  = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    pipe_entry #(.INS_W(INS_W), .PC_W(PC_W), .VEC_W(VEC_W)) u_main (
        .clk         (clk),
        .reset       (reset),
        .load        (main_load),
        .clear       (main_clear),
        .ins         (main_from_skid ? skid_ins    : in_ins),
        .pc_4        (main_from_skid ? skid_pc_4   : in_pc_4),
        .vector      (main_from_skid ? skid_vector : in_vector),
        .held_ins    (out_ins),
        .held_pc_4   (out_pc_4),
        .held_vector (out_vector)
    );

    pipe_entry #(.INS_W(INS_W), .PC_W(PC_W), .VEC_W(VEC_W)) u_skid (
        .clk         (clk),
        .reset       (reset),
        .load        (skid_load),
        .clear       (skid_clear),
        .ins         (in_ins),
        .pc_4        (in_pc_4),
        .vector      (in_vector),
        .held_ins    (skid_ins),
        .held_pc_4   (skid_pc_4),
        .held_vector (skid_vector)
    );

    assign held    = (state == ST_FULL) ? 2'd2 : (state == ST_ONE) ? 2'd1 : 2'd0;
    assign cnt_sum = {1'b0, flush_cnt} + (CNT_W+1)'(held);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     flush_cnt <= '0;
        else if (flush) flush_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed scenario tests for pipe_skid_reg, plus a CNT_W=2 copy for saturation.
module tb_pipe_skid_reg;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [31:0] in_ins = '0, in_pc_4 = '0;
    logic [4:0]  in_vector = '0;
    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [31:0] out_ins, out_pc_4, out_ins2, out_pc_42;
    logic [4:0]  out_vector, out_vector2;
    logic [15:0] flush_cnt;
    logic [1:0]  flush_cnt2;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    pipe_skid_reg dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_ins(in_ins), .in_pc_4(in_pc_4), .in_vector(in_vector),
        .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins),
        .out_pc_4(out_pc_4), .out_vector(out_vector), .flush(flush), .flush_cnt(flush_cnt)
    );

    pipe_skid_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_ins(in_ins), .in_pc_4(in_pc_4), .in_vector(in_vector),
        .out_valid(out_valid2), .out_ready(out_ready), .out_ins(out_ins2),
        .out_pc_4(out_pc_42), .out_vector(out_vector2), .flush(flush), .flush_cnt(flush_cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passed++;
        total++; if (out_ins !== 32'h0) $display("FAIL reset_out_ins got %h exp 0", out_ins); else passed++;
        total++; if (flush_cnt !== 16'd0) $display("FAIL reset_flush_cnt got %0d exp 0", flush_cnt); else passed++;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] exp_ins [3] = '{32'h11, 32'h22, 32'h33};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        foreach (exp_ins[i]) begin
            in_ins  = exp_ins[i];
            in_pc_4 = 32'h100 + 4 * i;
            tick();
            total++; if (out_valid !== 1'b1 || out_ins !== exp_ins[i])
                $display("FAIL stream_%0d got v=%b ins=%h exp v=1 ins=%h", i, out_valid, out_ins, exp_ins[i]); else passed++;
            total++; if (out_pc_4 !== 32'h100 + 4 * i)
                $display("FAIL stream_pc_%0d got %h exp %h", i, out_pc_4, 32'h100 + 4 * i); else passed++;
            total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready_%0d got %b exp 1", i, in_ready); else passed++;
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0 || out_ins !== 32'h0 || out_pc_4 !== 32'h0)
            $display("FAIL stream_drain got v=%b ins=%h pc=%h exp v=0 ins=0 pc=0", out_valid, out_ins, out_pc_4); else passed++;
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ins    = 32'hA1;
        tick();
        total++; if (out_ins !== 32'hA1 || in_ready !== 1'b1)
            $display("FAIL bp_first got ins=%h rdy=%b exp ins=a1 rdy=1", out_ins, in_ready); else passed++;
        in_ins = 32'hA2;
        tick();
        total++; if (out_ins !== 32'hA1 || in_ready !== 1'b0)
            $display("FAIL bp_full got ins=%h rdy=%b exp ins=a1 rdy=0", out_ins, in_ready); else passed++;
        in_ins = 32'hA3;
        tick();
        total++; if (out_ins !== 32'hA1 || in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL bp_hold got ins=%h rdy=%b v=%b exp ins=a1 rdy=0 v=1", out_ins, in_ready, out_valid); else passed++;
        out_ready = 1'b1;
        tick();
        total++; if (out_ins !== 32'hA2 || in_ready !== 1'b1)
            $display("FAIL bp_pop_a2 got ins=%h rdy=%b exp ins=a2 rdy=1", out_ins, in_ready); else passed++;
        tick();
        total++; if (out_ins !== 32'hA3 || out_valid !== 1'b1)
            $display("FAIL bp_pop_a3 got ins=%h v=%b exp ins=a3 v=1", out_ins, out_valid); else passed++;
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL bp_drain got v=%b exp 0", out_valid); else passed++;
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ins    = 32'hB1;
        in_vector = 5'h3;
        tick();
        in_ins = 32'hB2;
        tick();
        in_ins = 32'hB3;
        flush  = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_state got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); else passed++;
        total++; if (out_ins !== 32'h0 || out_pc_4 !== 32'h0 || out_vector !== 5'h0)
            $display("FAIL flush_nop got ins=%h pc=%h vec=%h exp all 0", out_ins, out_pc_4, out_vector); else passed++;
        total++; if (flush_cnt !== 16'd2) $display("FAIL flush_cnt got %0d exp 2", flush_cnt); else passed++;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_vector = 5'h0;
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || out_ins !== 32'h0)
            $display("FAIL flush_no_b3 got v=%b ins=%h exp v=0 ins=0", out_valid, out_ins); else passed++;
    endtask

    task automatic test_pop_empty();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ins    = 32'hDEADBEEF;
        in_vector = 5'h1F;
        in_pc_4   = 32'h1004;
        tick();
        total++; if (out_ins !== 32'hDEADBEEF || out_vector !== 5'h1F || out_pc_4 !== 32'h1004)
            $display("FAIL pop_load got ins=%h vec=%h pc=%h exp deadbeef 1f 1004", out_ins, out_vector, out_pc_4); else passed++;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || out_ins !== 32'h0 || out_vector !== 5'h0 || out_pc_4 !== 32'h0)
            $display("FAIL pop_zero got v=%b ins=%h vec=%h pc=%h exp all 0", out_valid, out_ins, out_vector, out_pc_4); else passed++;
        in_vector = 5'h0;
    endtask

    task automatic test_saturation();
        logic [1:0]  exp2 [3] = '{2'd2, 2'd3, 2'd3};
        logic [15:0] exp16 [3] = '{16'd2, 16'd4, 16'd6};
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        total++; if (flush_cnt2 !== 2'd0) $display("FAIL sat_start got %0d exp 0", flush_cnt2); else passed++;
        foreach (exp2[i]) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_ins    = 32'hC0 + i;
            tick();
            tick();
            in_valid = 1'b0;
            flush    = 1'b1;
            tick();
            flush = 1'b0;
            total++; if (flush_cnt2 !== exp2[i]) $display("FAIL sat_%0d got %0d exp %0d", i, flush_cnt2, exp2[i]); else passed++;
            total++; if (flush_cnt !== exp16[i]) $display("FAIL cnt16_%0d got %0d exp %0d", i, flush_cnt, exp16[i]); else passed++;
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ins    = 32'hE1;
        tick();
        in_ins = 32'hE2;
        tick();
        in_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_ins !== 32'h0 || in_ready !== 1'b1)
            $display("FAIL async_rst got v=%b ins=%h rdy=%b exp v=0 ins=0 rdy=1", out_valid, out_ins, in_ready); else passed++;
        total++; if (flush_cnt !== 16'd0) $display("FAIL async_rst_cnt got %0d exp 0", flush_cnt); else passed++;
        tick();
        reset = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || flush_cnt !== 16'd0)
            $display("FAIL async_rst_after got v=%b cnt=%0d exp v=0 cnt=0", out_valid, flush_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush_full();
        test_pop_empty();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
